// File: rtl/dma_copy_if.sv
// dma_copy_if: req/addr_ok/data_ok bus between the copy engine (master) and the RAM (slave).
interface dma_copy_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic            req;
   logic            write;
   logic [DW/8-1:0] wstrb;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic            addr_ok;
   logic            data_ok;
   logic [DW-1:0]   rdata;
   modport master (output req, write, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
   modport slave (input req, write, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine, one outstanding bus transaction.
// Define DMA_FILL_EN to enable pattern fill mode; otherwise fill_i/fill_data_i are ignored.
module dma_copy #(
   parameter int AW = 12,
   parameter int DW = 32,
   parameter int LW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [AW-1:0] src_addr_i,
   input  logic [AW-1:0] dst_addr_i,
   input  logic [LW-1:0] len_i,
   input  logic          fill_i,
   input  logic [DW-1:0] fill_data_i,
   output logic          busy_o,
   output logic          done_o,
   dma_copy_if.master    bus
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_e;
   state_e          state_q;
   logic [AW-1:0]   src_q, dst_q, addr_q, src_d, dst_d;
   logic [LW-1:0]   rem_q, rem_d;
   logic [DW-1:0]   wdata_q, fill_word;
   logic [DW/8-1:0] wstrb_q;
   logic            fill_q, busy_q, done_q, req_q, write_q, fill_en;
`ifdef DMA_FILL_EN
   assign fill_en   = fill_i;
   assign fill_word = fill_data_i;
`else
   logic unused_fill;
   assign fill_en     = 1'b0;
   assign fill_word   = '0;
   assign unused_fill = ^{fill_i, fill_data_i};
`endif
   assign src_d = src_q + 1'b1;
   assign dst_d = dst_q + 1'b1;
   assign rem_d = rem_q - 1'b1;
   // wdata_q doubles as the read buffer; in fill mode it holds the pattern for the whole run
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         fill_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
         write_q <= 1'b0;
         wstrb_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               src_q  <= src_addr_i;
               dst_q  <= dst_addr_i;
               rem_q  <= len_i;
               fill_q <= fill_en;
               busy_q <= 1'b1;
               if (len_i == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else if (fill_en) begin
                  state_q <= WR_REQ;
                  req_q   <= 1'b1;
                  write_q <= 1'b1;
                  wstrb_q <= '1;
                  addr_q  <= dst_addr_i;
                  wdata_q <= fill_word;
               end else begin
                  state_q <= RD_REQ;
                  req_q   <= 1'b1;
                  write_q <= 1'b0;
                  wstrb_q <= '0;
                  addr_q  <= src_addr_i;
               end
            end
            RD_REQ: if (bus.addr_ok) begin
               state_q <= RD_WAIT;
               req_q   <= 1'b0;
            end
            RD_WAIT: if (bus.data_ok) begin
               state_q <= WR_REQ;
               wdata_q <= bus.rdata;
               req_q   <= 1'b1;
               write_q <= 1'b1;
               wstrb_q <= '1;
               addr_q  <= dst_q;
            end
            WR_REQ: if (bus.addr_ok) begin
               src_q <= src_d;
               dst_q <= dst_d;
               rem_q <= rem_d;
               if (rem_d == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  req_q   <= 1'b0;
                  write_q <= 1'b0;
                  wstrb_q <= '0;
               end else if (fill_q) begin
                  addr_q <= dst_d;
               end else begin
                  state_q <= RD_REQ;
                  write_q <= 1'b0;
                  wstrb_q <= '0;
                  addr_q  <= src_d;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign bus.req   = req_q;
   assign bus.write = write_q;
   assign bus.wstrb = wstrb_q;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;
endmodule
